// File: rtl/bell_scheduler.sv
// bell_scheduler: arbitrates four note requesters onto one bell with hold/gap timing and fixed-priority preemption
// Ports: clk/rst (async active-high); req[i] level request, note[3i+2:3i] tone code (0 = silence),
//        prio_mode 0 = fixed (3 highest) / 1 = round-robin; grant one-hot owner, bell_code latched tone,
//        busy = PLAY or GAP, done[i] one-cycle pulse when requester i's note completes normally.
module bell_scheduler #(
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 250,
  parameter int GAP_TICKS  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [11:0] note,
  input  logic        prio_mode,
  output logic [3:0]  grant,
  output logic [2:0]  bell_code,
  output logic        busy,
  output logic [3:0]  done
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_pre;
  logic [9:0] r_tick;
  logic [3:0] r_grant, r_done, w_elig;
  logic [2:0] r_code;
  logic [1:0] r_rr, w_fix, w_rr, w_win;
  logic w_rr_hit, w_load, w_clr, w_tick, w_play_end, w_gap_end, w_preempt;
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < 4; i++) w_elig[i] = req[i] && (note[3*i +: 3] != 3'd0);
  end
  assign w_fix = w_elig[3] ? 2'd3 : w_elig[2] ? 2'd2 : w_elig[1] ? 2'd1 : 2'd0;
  // search upward from the slot after the last winner, wrapping mod 4
  always_comb begin
    logic [1:0] idx;
    w_rr = r_rr;
    w_rr_hit = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = r_rr + 2'(k);
      if (!w_rr_hit && w_elig[idx]) begin
        w_rr_hit = 1'b1;
        w_rr = idx;
      end
    end
  end
  assign w_win      = prio_mode ? w_rr : w_fix;
  assign w_tick     = r_pre == PW'(TICK_DIV - 1);
  assign w_play_end = w_tick && r_tick == 10'(HOLD_TICKS - 1);
  assign w_gap_end  = w_tick && r_tick == 10'(GAP_TICKS - 1);
  assign w_preempt  = !prio_mode && w_elig[3] && !r_grant[3];
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = |w_elig ? PLAY : IDLE;
        w_load = |w_elig;
      end
      PLAY: begin
        w_next = w_play_end ? GAP : PLAY;
        w_load = !w_play_end && w_preempt;
      end
      GAP: w_next = w_gap_end ? IDLE : GAP;
      default: w_next = IDLE;
    endcase
  end
  // a preemption restarts PLAY, so it clears the timers like a state entry
  assign w_clr = w_load || w_next != r_state || r_state == IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_tick  <= '0;
      r_grant <= '0;
      r_code  <= '0;
      r_done  <= '0;
      r_rr    <= 2'd3;
    end else begin
      r_state <= w_next;
      r_done  <= '0;
      if (w_clr) begin
        r_pre  <= '0;
        r_tick <= '0;
      end else if (w_tick) begin
        r_pre  <= '0;
        r_tick <= r_tick + 10'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      if (w_load) begin
        r_grant <= 4'b0001 << w_win;
        r_code  <= note[3*w_win +: 3];
        r_rr    <= w_win;
      end else if (r_state == PLAY && w_play_end) begin
        r_grant <= '0;
        r_code  <= '0;
        r_done  <= r_grant;
      end
    end
  end
  assign grant     = r_grant;
  assign bell_code = r_code;
  assign done      = r_done;
  assign busy      = r_state != IDLE;
endmodule

// File: doc/bell_scheduler.md
BELL_SCHEDULER -- requirements
Module: bell_scheduler

Interface
REQ-001 Parameter TICK_DIV, 50000, clk cycles per time tick (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter HOLD_TICKS, 250, ticks a granted note sounds; legal range 1..1023.
REQ-003 Parameter GAP_TICKS, 20, silent ticks after each note; legal range 1..1023.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  4  level request per requester i.
REQ-007 note  in  12  note code of requester i on note[3i+2:3i]; 1..7 are tones, 0 is silence.
REQ-008 prio_mode  in  1  0 = fixed priority (index 3 highest), 1 = round-robin.
REQ-009 grant  out  4  one-hot owner of the bell; all zero when none.
REQ-010 bell_code  out  3  registered code driven to the bell tone generator.
REQ-011 busy  out  1  high in PLAY or GAP.
REQ-012 done  out  4  one-cycle pulse on bit i when requester i's note completes normally.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, PLAY and GAP.
REQ-014 A requester SHALL be eligible when req[i]=1 and its note field is non-zero; ineligible requests SHALL be ignored.
REQ-015 In IDLE, with at least one eligible requester in cycle N, the FSM SHALL enter PLAY at edge N+1 with grant, bell_code and the latched note valid from that edge.
REQ-016 With prio_mode=0, the highest-index eligible requester SHALL win.
REQ-017 With prio_mode=1, the winner SHALL be the first eligible index after rr_ptr, searching upward mod 4; rr_ptr SHALL update to the winner on every grant.
REQ-018 The note code SHALL be latched at grant; changes to note or req during PLAY SHALL NOT alter bell_code.
REQ-019 The tick prescaler and tick counter SHALL clear on every state entry, so PLAY lasts exactly HOLD_TICKS*TICK_DIV cycles and GAP lasts exactly GAP_TICKS*TICK_DIV cycles.
REQ-020 At the end of PLAY the FSM SHALL enter GAP and, on the same edge, clear grant, force bell_code to 0 and pulse done for the owner.
REQ-021 At the end of GAP the FSM SHALL enter IDLE; arbitration SHALL resume in IDLE on the following cycle.
REQ-022 Preemption: in PLAY with prio_mode=0, an eligible req[3] SHALL cause, when the owner is not 3, grant=4'b1000, bell_code=note[11:9] and a PLAY restart on the next edge, with no done pulse for the preempted owner.
REQ-023 No preemption SHALL occur with prio_mode=1 or while in GAP.
REQ-024 A requester that holds req high after done SHALL be re-arbitrated normally after GAP. This allows back-to-back notes from one requester when it is the sole requester.
REQ-025 grant SHALL be one-hot or zero in every cycle; busy SHALL equal (state != IDLE).
REQ-026 A change of prio_mode SHALL take effect at the next arbitration or preemption check; it SHALL NOT affect the note in progress.

Reset
REQ-027 While rst=1, the block SHALL immediately set state=IDLE, grant=0, bell_code=0, busy=0, done=0, rr_ptr=3, and both counters to 0.
REQ-028 Reset asserted during PLAY or GAP SHALL silence the bell asynchronously, without a done pulse.
REQ-029 After rst deasserts, the first arbitration SHALL take place on the first clk edge in IDLE.

Verification (TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2)
REQ-030 Single request: req=0001, note[2:0]=5 at cycle 0 -> grant=0001 and bell_code=5 from cycle 1 for 12 cycles; done[0] pulses and bell_code=0 at cycle 13; busy falls at cycle 21.
REQ-031 Fixed priority: req=0110, notes 2 and 3, prio_mode=0 -> requester 2 is granted first with bell_code=3; requester 1 is granted after GAP with bell_code=2.
REQ-032 Round-robin: req=1111 held, all notes non-zero, prio_mode=1 -> grant sequence 0001, 0010, 0100, 1000, 0001 after reset, each separated by a GAP.
REQ-033 Preemption: requester 0 playing, req[3] rises with note 7 mid-PLAY -> next edge grant=1000, bell_code=7, full 12-cycle PLAY, done[3] only, done[0] never pulses.
REQ-034 Zero note and reset: req=0001 with note 0 -> stays IDLE; then note 4 granted and rst pulsed at cycle 5 -> grant=0, bell_code=0, busy=0 immediately, no done.
